// File: rtl/store_pkg.sv
// Shared definitions for the store alignment path: the access-size encodings,
// the FIFO occupancy states and the byte-enable patterns.
package store_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    Empty = 2'd0,
    One   = 2'd1,
    Two   = 2'd2
  } occ_e;

  localparam logic [3:0] BeNone   = 4'b0000;
  localparam logic [3:0] BeByte   = 4'b0001;
  localparam logic [3:0] BeHalfLo = 4'b0011;
  localparam logic [3:0] BeHalfHi = 4'b1100;
  localparam logic [3:0] BeWord   = 4'b1111;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational lane formatter: turns a register value plus size and the low
// address bits into little-endian lane-aligned write data and byte enables.
// The misaligned flag is consumed only when STORE_MISALIGN_TRAP_EN is defined.
module store_lane_fmt
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic [3:0]  be,
  output logic        misaligned
);

  // Replicate the narrow value into every lane; be selects the lanes written.
  always_comb begin
    out_data   = 32'h0;
    be         = BeNone;
    misaligned = 1'b0;
    unique case (size)
      SizeByte: begin
        out_data = {4{in_data[7:0]}};
        be       = BeByte << addr;
      end
      SizeHalf: begin
        out_data   = {2{in_data[15:0]}};
        be         = addr[1] ? BeHalfHi : BeHalfLo;
        misaligned = addr[0];
      end
      SizeWord: begin
        out_data   = in_data;
        be         = BeWord;
        misaligned = (addr != 2'b00);
      end
      default: begin
        // Reserved size: never enqueued, outputs unused.
      end
    endcase
  end

endmodule

// File: rtl/store_align.sv
// Store alignment stage: accepts store requests, formats them into lane-aligned
// word writes and buffers them in a 2-entry in-order FIFO. Reserved sizes raise
// a one-cycle error pulse instead of being enqueued.
// Optional: define STORE_MISALIGN_TRAP_EN to also trap misaligned half/word stores.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       store_cnt
);

  logic [31:0]       fmt_data;
  logic [3:0]        fmt_be;
  logic              fmt_misaligned;
  logic [ADDR_W-1:0] new_addr;
  logic              accept;
  logic              is_err;
  logic              push;
  logic              drain;

  occ_e              state_q, state_d;
  logic [ADDR_W-1:0] tail_addr_q;
  logic [31:0]       tail_data_q;
  logic [3:0]        tail_be_q;

  store_lane_fmt u_fmt (
    .size       (in_size),
    .addr       (in_addr[1:0]),
    .in_data    (in_data),
    .out_data   (fmt_data),
    .be         (fmt_be),
    .misaligned (fmt_misaligned)
  );

  assign new_addr = {in_addr[ADDR_W-1:2], 2'b00};
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

`ifdef STORE_MISALIGN_TRAP_EN
  assign is_err = (in_size == SizeRsvd) || fmt_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = fmt_misaligned;
  assign is_err = (in_size == SizeRsvd);
`endif

  assign push = accept && !is_err;

  // Occupancy next state: push-only goes up, drain-only goes down, both hold.
  always_comb begin
    state_d = state_q;
    if (push && !drain) begin
      state_d = (state_q == Empty) ? One : Two;
    end else if (!push && drain) begin
      state_d = (state_q == Two) ? One : Empty;
    end
  end

  // FIFO state and registered handshake/output registers; the output
  // registers are the FIFO head, the tail entry holds the second store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= Empty;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= 32'h0;
      out_be      <= BeNone;
      tail_addr_q <= '0;
      tail_data_q <= 32'h0;
      tail_be_q   <= BeNone;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != Two);
      out_valid <= (state_d != Empty);
      if (push) begin
        // In Two in_ready is low, so a push only ever sees Empty or One.
        if (state_q == Empty || drain) begin
          out_addr <= new_addr;
          out_data <= fmt_data;
          out_be   <= fmt_be;
        end else begin
          tail_addr_q <= new_addr;
          tail_data_q <= fmt_data;
          tail_be_q   <= fmt_be;
        end
      end else if (drain && state_q == Two) begin
        out_addr <= tail_addr_q;
        out_data <= tail_data_q;
        out_be   <= tail_be_q;
      end
    end
  end

  // Error pulse with sticky faulting address, and the wrapping commit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      store_cnt <= 16'h0;
    end else begin
      err_valid <= accept && is_err;
      if (accept && is_err) begin
        err_addr <= in_addr;
      end
      if (drain) begin
        store_cnt <= store_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: directed steps plus random traffic, all compared
// against a queue-based reference model of the store buffer.
module tb_store_align;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [15:0] store_cnt;

  store_align #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_be    (out_be),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .store_cnt (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         mq[$];
  logic        m_ready;
  logic        m_err;
  logic [31:0] m_err_addr;
  logic [15:0] m_cnt;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wr_t w;
    int  lane;
    lane   = int'(a % 32'd4);
    w.addr = a - 32'(lane);
    case (s)
      2'd0: begin
        w.data = 32'(d[7:0]) * 32'h01010101;
        w.be   = 4'(1 << lane);
      end
      2'd1: begin
        w.data = 32'(d[15:0]) * 32'h00010001;
        w.be   = (lane >= 2) ? 4'hC : 4'h3;
      end
      default: begin
        w.data = d;
        w.be   = 4'hF;
      end
    endcase
    return w;
  endfunction

  function automatic bit bad(input logic [31:0] a, input logic [1:0] s);
`ifdef STORE_MISALIGN_TRAP_EN
    return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
`else
    return (s == 2'd3);
`endif
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit acc;
    bit drn;
    if (!rst_n) begin
      mq.delete();
      m_ready    = 1'b0;
      m_err      = 1'b0;
      m_err_addr = 32'h0;
      m_cnt      = 16'h0;
      return;
    end
    acc   = in_valid && m_ready;
    drn   = (mq.size() > 0) && out_ready;
    m_err = 1'b0;
    if (drn) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (acc) begin
      if (bad(in_addr, in_size)) begin
        m_err      = 1'b1;
        m_err_addr = in_addr;
      end else begin
        mq.push_back(fmt(in_addr, in_data, in_size));
      end
    end
    m_ready = (mq.size() < 2);
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_addr", 64'(out_addr), 64'(mq[0].addr));
      chk("out_data", 64'(out_data), 64'(mq[0].data));
      chk("out_be", 64'(out_be), 64'(mq[0].be));
    end
    chk("err_valid", 64'(err_valid), 64'(m_err));
    chk("err_addr", 64'(err_addr), 64'(m_err_addr));
    chk("store_cnt", 64'(store_cnt), 64'(m_cnt));
  endtask

  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic ordy);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    in_size   = s;
    out_ready = ordy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'h0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_out_addr"}, 64'(out_addr), 64'h0);
    chk({tag, "_out_data"}, 64'(out_data), 64'h0);
    chk({tag, "_out_be"}, 64'(out_be), 64'h0);
    chk({tag, "_err_valid"}, 64'(err_valid), 64'h0);
    chk({tag, "_err_addr"}, 64'(err_addr), 64'h0);
    chk({tag, "_store_cnt"}, 64'(store_cnt), 64'h0);
  endtask

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    mq.delete();
    m_ready = 1'b0;
    m_err = 1'b0;
    m_err_addr = 32'h0;
    m_cnt = 16'h0;

    // Power-on reset.
    rst_n = 1'b0;
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("ready_after_reset", 64'(in_ready), 64'h1);

    // Byte store into lane 3.
    tick(1'b1, 32'h103, 32'hAABBCCDD, 2'd0, 1'b1);
    chk("byte_addr", 64'(out_addr), 64'h100);
    chk("byte_data", 64'(out_data), 64'hDDDDDDDD);
    chk("byte_be", 64'(out_be), 64'h8);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("byte_cnt", 64'(store_cnt), 64'h1);

    // Half store into the upper halfword.
    tick(1'b1, 32'h22, 32'h00001234, 2'd1, 1'b1);
    chk("half_data", 64'(out_data), 64'h12341234);
    chk("half_be", 64'(out_be), 64'hC);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Misaligned word store.
    tick(1'b1, 32'h41, 32'hCAFEF00D, 2'd2, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    chk("mis_err_valid", 64'(err_valid), 64'h1);
    chk("mis_err_addr", 64'(err_addr), 64'h41);
    chk("mis_no_out", 64'(out_valid), 64'h0);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("mis_err_pulse", 64'(err_valid), 64'h0);
    chk("mis_err_hold", 64'(err_addr), 64'h41);
`else
    chk("mis_addr", 64'(out_addr), 64'h40);
    chk("mis_be", 64'(out_be), 64'hF);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
`endif

    // Reserved size.
    tick(1'b1, 32'h77, 32'h1, 2'd3, 1'b1);
    chk("rsvd_err", 64'(err_valid), 64'h1);
    chk("rsvd_addr", 64'(err_addr), 64'h77);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Backpressure: third request is held off, then drain in order.
    tick(1'b1, 32'h200, 32'h11111111, 2'd2, 1'b0);
    chk("bp_ready1", 64'(in_ready), 64'h1);
    tick(1'b1, 32'h204, 32'h22222222, 2'd2, 1'b0);
    chk("bp_ready2", 64'(in_ready), 64'h0);
    tick(1'b1, 32'h208, 32'h33333333, 2'd2, 1'b0);
    chk("bp_ready3", 64'(in_ready), 64'h0);
    chk("bp_hold_data", 64'(out_data), 64'h11111111);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    chk("bp_stall_addr", 64'(out_addr), 64'h200);
    chk("bp_stall_data", 64'(out_data), 64'h11111111);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("bp_drain2_addr", 64'(out_addr), 64'h204);
    chk("bp_drain2_data", 64'(out_data), 64'h22222222);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("bp_empty", 64'(out_valid), 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick(1'(($urandom % 3) != 0), $urandom, $urandom, 2'($urandom % 4),
           1'(($urandom % 4) != 0));
    end

    // Reset with two entries buffered.
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    tick(1'b1, 32'h300, 32'h44444444, 2'd2, 1'b0);
    tick(1'b1, 32'h304, 32'h55555555, 2'd2, 1'b0);
    chk("full_before_rst", 64'(in_ready), 64'h0);
    rst_n = 1'b0;
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    chk_zero("midrst");
    rst_n = 1'b1;
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    chk("post_rst_err", 64'(err_valid), 64'h0);
    tick(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    chk("post_rst_valid2", 64'(out_valid), 64'h0);

    // Counter wrap after 65535 commits.
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      tick(1'b1, $urandom & 32'hFFFFFFFC, $urandom, 2'd2, 1'b1);
      guard++;
    end
    chk("pre_wrap_cnt", 64'(store_cnt), 64'hFFFF);
    tick(1'b1, 32'h400, 32'h66666666, 2'd2, 1'b1);
    chk("cnt_wrap", 64'(store_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
